// File: rtl/frame_arb_pkg.sv
// Shared types for frame_dispatch_arbiter: FSM states, descriptor config fields and widths.
package frame_arb_pkg;

    localparam int DEPTH_W  = 16;
    localparam int STRIDE_W = 8;
    localparam int HINTS_W  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    // The base address width is a top-level parameter, so it is kept out of this struct.
    typedef struct packed {
        logic [DEPTH_W-1:0]  depth;
        logic [STRIDE_W-1:0] stride;
        logic [HINTS_W-1:0]  hints;
    } frame_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/frame_dispatch_arbiter.sv
// Round-robin dispatcher sharing one frame_controller among NUM_REQ descriptor sources.
// Optional perf counters are built only when FRAME_ARB_PERF_EN is defined.
module frame_dispatch_arbiter
    import frame_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr,
    input  logic [NUM_REQ*16-1:0]         req_frame_depth,
    input  logic [NUM_REQ*8-1:0]          req_lane_stride,
    input  logic [NUM_REQ*32-1:0]         req_exec_hints,
    output logic [NUM_REQ-1:0]            done_pulse,
    output logic                          done_err,
    output logic [ADDR_WIDTH-1:0]         fc_base_addr,
    output logic [15:0]                   fc_frame_depth,
    output logic [7:0]                    fc_lane_stride,
    output logic [31:0]                   fc_exec_hints,
    output logic                          fc_start_trigger,
    input  logic                          fc_frame_done,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [31:0]                   perf_busy_cycles,
    output logic [31:0]                   perf_frames
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        frame_cfg_t            cfg;
    } frame_desc_t;

    arb_state_t       r_state;
    frame_desc_t      r_desc;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant_id;
    logic [NUM_REQ-1:0] r_done_pulse;
    logic             r_done_err;
    logic             r_start;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    frame_desc_t        w_sel;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        f_next = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel            = '0;
        w_sel.base       = req_base_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel.cfg.depth  = req_frame_depth[int'(w_idx)*DEPTH_W +: DEPTH_W];
        w_sel.cfg.stride = req_lane_stride[int'(w_idx)*STRIDE_W +: STRIDE_W];
        w_sel.cfg.hints  = req_exec_hints[int'(w_idx)*HINTS_W +: HINTS_W];
    end

    // Ready is a decode of the registered state, so valid&ready marks the accept cycle.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_desc       <= '0;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_done_pulse <= '0;
            r_done_err   <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            r_done_pulse <= '0;
            r_done_err   <= 1'b0;
            r_start      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_desc     <= w_sel;
                        r_grant_id <= w_idx;
                        // Zero-depth descriptors are bounced straight back with an error.
                        if (w_sel.cfg.depth == '0) begin
                            r_done_pulse <= w_grant;
                            r_done_err   <= 1'b1;
                            r_rr_ptr     <= f_next(w_idx);
                        end else begin
                            r_start <= 1'b1;
                            r_state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (fc_frame_done) begin
                        r_done_pulse <= NUM_REQ'(1) << r_grant_id;
                        r_rr_ptr     <= f_next(r_grant_id);
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fc_base_addr     = r_desc.base;
    assign fc_frame_depth   = r_desc.cfg.depth;
    assign fc_lane_stride   = r_desc.cfg.stride;
    assign fc_exec_hints    = r_desc.cfg.hints;
    assign fc_start_trigger = r_start;
    assign done_pulse       = r_done_pulse;
    assign done_err         = r_done_err;
    assign busy             = (r_state != IDLE);
    assign grant_id         = r_grant_id;

`ifdef FRAME_ARB_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_frames;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_busy   <= '0;
            r_perf_frames <= '0;
        end else begin
            if (r_state != IDLE && r_perf_busy != 32'hFFFF_FFFF) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (r_state == WAIT_DONE && fc_frame_done && r_perf_frames != 32'hFFFF_FFFF) begin
                r_perf_frames <= r_perf_frames + 32'd1;
            end
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_frames      = r_perf_frames;
`else
    assign perf_busy_cycles = '0;
    assign perf_frames      = '0;
`endif

endmodule

// File: tb/tb_frame_dispatch_arbiter.sv
// Self-checking bench for frame_dispatch_arbiter: table of grant vectors plus reset/perf sequences.
module tb_frame_dispatch_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_base_addr;
    logic [NR*16-1:0]  req_frame_depth;
    logic [NR*8-1:0]   req_lane_stride;
    logic [NR*32-1:0]  req_exec_hints;
    logic [NR-1:0]     done_pulse;
    logic              done_err;
    logic [AW-1:0]     fc_base_addr;
    logic [15:0]       fc_frame_depth;
    logic [7:0]        fc_lane_stride;
    logic [31:0]       fc_exec_hints;
    logic              fc_start_trigger;
    logic              fc_frame_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic [31:0]       perf_busy_cycles;
    logic [31:0]       perf_frames;

    frame_dispatch_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_base_addr    (req_base_addr),
        .req_frame_depth  (req_frame_depth),
        .req_lane_stride  (req_lane_stride),
        .req_exec_hints   (req_exec_hints),
        .done_pulse       (done_pulse),
        .done_err         (done_err),
        .fc_base_addr     (fc_base_addr),
        .fc_frame_depth   (fc_frame_depth),
        .fc_lane_stride   (fc_lane_stride),
        .fc_exec_hints    (fc_exec_hints),
        .fc_start_trigger (fc_start_trigger),
        .fc_frame_done    (fc_frame_done),
        .busy             (busy),
        .grant_id         (grant_id),
        .perf_busy_cycles (perf_busy_cycles),
        .perf_frames      (perf_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  zero;
        logic [31:0] seed;
        int          lat;
        int          exp_g;
        bit          exp_err;
        bit          spur;
    } vec_t;

    typedef struct {
        int          g;
        bit          err;
        logic [31:0] base;
        logic [15:0] depth;
        logic [7:0]  stride;
        logic [31:0] hints;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   total = 0;
    int   bad = 0;
    int   trig_cnt = 0;
    int   exp_trigs = 0;

    always @(negedge clk) begin
        if (!reset && fc_start_trigger) trig_cnt <= trig_cnt + 1;
    end

    function automatic logic [31:0] f_base(input logic [31:0] seed, input int i);
        return seed + 32'h100 * i;
    endfunction
    function automatic logic [15:0] f_depth(input logic [3:0] zero, input int i);
        return zero[i] ? 16'd0 : 16'(3 + i);
    endfunction
    function automatic logic [7:0] f_stride(input int i);
        return 8'(i + 1);
    endfunction
    function automatic logic [31:0] f_hints(input logic [31:0] seed, input int i);
        return seed ^ 32'hA500_0000 ^ (32'(i) << 8);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic drive_slices(input logic [31:0] seed, input logic [3:0] zero);
        for (int i = 0; i < NR; i++) begin
            req_base_addr[i*AW +: AW]  = f_base(seed, i);
            req_frame_depth[i*16 +: 16] = f_depth(zero, i);
            req_lane_stride[i*8 +: 8]   = f_stride(i);
            req_exec_hints[i*32 +: 32]  = f_hints(seed, i);
        end
    endtask

    // One descriptor from presentation to completion; lat = cycles from LAUNCH to frame_done.
    task automatic run_txn(input logic [3:0] mask, input logic [3:0] zero, input logic [31:0] seed,
                           input int lat, input int exp_g, input bit exp_err, input bit spur);
        exp_t e;
        @(negedge clk);
        drive_slices(seed, zero);
        req_valid = mask;
        e.g      = exp_g;
        e.err    = exp_err;
        e.base   = f_base(seed, exp_g);
        e.depth  = f_depth(zero, exp_g);
        e.stride = f_stride(exp_g);
        e.hints  = f_hints(seed, exp_g);
        sb.push_back(e);
        #1;
        chk("req_ready", 64'(req_ready), 64'(1) << exp_g);
        chk("busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = '0;
        chk("grant_id", 64'(grant_id), 64'(exp_g));
        if (exp_err) begin
            e = sb.pop_front();
            chk("no_trigger_err", 64'(fc_start_trigger), 64'd0);
            chk("done_pulse_err", 64'(done_pulse), 64'(1) << e.g);
            chk("done_err_set", 64'(done_err), 64'd1);
            chk("fc_depth_err", 64'(fc_frame_depth), 64'(e.depth));
        end else begin
            exp_trigs++;
            chk("fc_start", 64'(fc_start_trigger), 64'd1);
            chk("fc_base", 64'(fc_base_addr), 64'(sb[0].base));
            chk("fc_depth", 64'(fc_frame_depth), 64'(sb[0].depth));
            chk("fc_stride", 64'(fc_lane_stride), 64'(sb[0].stride));
            chk("fc_hints", 64'(fc_exec_hints), 64'(sb[0].hints));
            if (spur) begin
                fc_frame_done = 1'b1;
                @(negedge clk);
                fc_frame_done = 1'b0;
                chk("spur_launch_done", 64'(done_pulse), 64'd0);
                chk("spur_launch_busy", 64'(busy), 64'd1);
                chk("single_trigger", 64'(fc_start_trigger), 64'd0);
            end
            repeat (lat) @(negedge clk);
            chk("no_early_done", 64'(done_pulse), 64'd0);
            fc_frame_done = 1'b1;
            @(negedge clk);
            fc_frame_done = 1'b0;
            e = sb.pop_front();
            chk("done_pulse", 64'(done_pulse), 64'(1) << e.g);
            chk("done_err_clr", 64'(done_err), 64'd0);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("fc_base_hold", 64'(fc_base_addr), 64'(e.base));
        end
    endtask

    initial begin
        //          mask     zero     seed          lat g  err spur
        vecs[0]  = '{4'b0010, 4'b0000, 32'h0000_0F00, 2, 1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 32'h0001_0000, 1, 2, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 32'h0002_0000, 3, 3, 1'b0, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0000, 32'h0003_0000, 4, 0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 32'h0004_0000, 5, 1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 4'b0100, 32'h0005_0000, 1, 2, 1'b1, 1'b0};
        vecs[6]  = '{4'b1001, 4'b0000, 32'h0006_0000, 2, 3, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 4'b0000, 32'h0007_0000, 1, 0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 4'b0000, 32'h0008_0000, 3, 3, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 4'b0001, 32'h0009_0000, 1, 0, 1'b1, 1'b0};
        vecs[10] = '{4'b0011, 4'b0000, 32'h000A_0000, 2, 1, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 4'b0000, 32'h000B_0000, 1, 2, 1'b0, 1'b0};

        reset           = 1'b1;
        req_valid       = '0;
        req_base_addr   = '0;
        req_frame_depth = '0;
        req_lane_stride = '0;
        req_exec_hints  = '0;
        fc_frame_done   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_pulse), 64'd0);
        chk("rst_trigger", 64'(fc_start_trigger), 64'd0);
        chk("rst_fc_base", 64'(fc_base_addr), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_perf_busy", 64'(perf_busy_cycles), 64'd0);
        reset = 1'b0;

        // Stray controller done while idle must be ignored.
        @(negedge clk);
        fc_frame_done = 1'b1;
        @(negedge clk);
        fc_frame_done = 1'b0;
        chk("spur_idle_done", 64'(done_pulse), 64'd0);
        chk("spur_idle_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 12; v++) begin
            run_txn(vecs[v].mask, vecs[v].zero, vecs[v].seed, vecs[v].lat,
                    vecs[v].exp_g, vecs[v].exp_err, vecs[v].spur);
        end
        @(negedge clk);
        chk("trigger_count", 64'(trig_cnt), 64'(exp_trigs));

        // Reset while waiting on the controller.
        @(negedge clk);
        drive_slices(32'h00C0_0000, 4'b0000);
        req_valid = 4'b0001;
        #1;
        chk("rst_seq_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rst_seq_waiting", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_fc_base", 64'(fc_base_addr), 64'd0);
        chk("midrst_fc_depth", 64'(fc_frame_depth), 64'd0);
        chk("midrst_done", 64'(done_pulse), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done_pulse), 64'd0);
        end

        // Three frames of 10 busy cycles each, starting from a fresh pointer.
        run_txn(4'b1111, 4'b0000, 32'h00D0_0000, 9, 0, 1'b0, 1'b0);
        run_txn(4'b1111, 4'b0000, 32'h00E0_0000, 9, 1, 1'b0, 1'b0);
        run_txn(4'b1111, 4'b0000, 32'h00F0_0000, 9, 2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
`ifdef FRAME_ARB_PERF_EN
        chk("perf_frames", 64'(perf_frames), 64'd3);
        chk("perf_busy_cycles", 64'(perf_busy_cycles), 64'd30);
`else
        chk("perf_frames", 64'(perf_frames), 64'd0);
        chk("perf_busy_cycles", 64'(perf_busy_cycles), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
